eth_time_base: RTL and testbench

- Free-running 64-bit time base that drives the current_time / time_running inputs of every eth_stats_collector instance in the design.
- Configured by the PS through a simple single-cycle register port, bridged from AXI4-Lite by the interconnect glue.
- Supports start/pause/resume, synchronous clear, and an optional auto-stop limit.
- Supports a tear-free 64-bit readback via a low/high snapshot.

---
 rtl/eth_time_base_pkg.sv | 30 +++
 rtl/eth_time_base.sv | 196 +++++++++++++++++++
 tb/tb_eth_time_base.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_time_base_pkg.sv
// eth_time_base_pkg
// Shared definitions for the eth_time_base register block: register byte
// offsets, CFG/STATUS bit positions and the time-base state encoding.
// Ports: none (package only).
package eth_time_base_pkg;

    // Register byte offsets (word aligned, 32-bit registers)
    localparam logic [31:0] REG_CFG     = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS  = 32'h0000_0004;
    localparam logic [31:0] REG_LIMIT_L = 32'h0000_0008;
    localparam logic [31:0] REG_LIMIT_H = 32'h0000_000C;
    localparam logic [31:0] REG_TIME_L  = 32'h0000_0010;
    localparam logic [31:0] REG_TIME_H  = 32'h0000_0014;

    // CFG bit positions
    localparam int CFG_ENABLE_BIT = 0;
    localparam int CFG_CLEAR_BIT  = 1;

    // STATUS bit positions
    localparam int STATUS_RUNNING_BIT = 0;
    localparam int STATUS_LIMIT_BIT   = 1;

    // Time-base states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LIMIT   = 2'd2
    } state_e;

endpackage

// File: rtl/eth_time_base.sv
// eth_time_base
// Free-running 64-bit time base shared by the statistics collectors.
// Software starts/pauses it through CFG.enable, clears it with the
// CFG.clear pulse and can make it stop automatically at a 64-bit LIMIT
// (LIMIT = 0 means unlimited). The 64-bit value can be read tear-free:
// reading TIME_L captures the upper word, which TIME_H then returns.
//
// Parameters:
//   C_STEP        increment per running cycle, legal range 1..255
//   C_ADDR_WIDTH  byte-address width of the register port (>= 5)
//
// Ports:
//   clk           single clock
//   rst           synchronous active-high reset
//   reg_wr_en     single-cycle write strobe
//   reg_rd_en     single-cycle read strobe
//   reg_addr      byte address shared by reads and writes
//   reg_wdata     write data
//   reg_rdata     read data, valid while reg_rvalid is high
//   reg_rvalid    one-cycle pulse, one cycle after reg_rd_en
//   current_time  64-bit time value
//   time_running  high while the time base is counting
module eth_time_base
    import eth_time_base_pkg::*;
#(
    parameter int C_STEP       = 8,
    parameter int C_ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reg_wr_en,
    input  logic                    reg_rd_en,
    input  logic [C_ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]             reg_wdata,
    output logic [31:0]             reg_rdata,
    output logic                    reg_rvalid,
    output logic [63:0]             current_time,
    output logic                    time_running
);

    localparam logic [63:0] STEP64 = 64'(C_STEP);

    logic        cfg_enable;
    logic        clear_pulse;
    logic [63:0] limit_value;
    logic [63:0] time_count;
    logic [63:0] count_next;
    logic [63:0] count_inc;
    logic [31:0] snapshot;
    logic [31:0] read_mux;
    logic [31:0] word_addr;
    logic        limit_active;
    logic        running_q;
    state_e      state;
    state_e      state_next;

    logic sel_cfg;
    logic sel_status;
    logic sel_limit_l;
    logic sel_limit_h;
    logic sel_time_l;
    logic sel_time_h;

    // The two low address bits are don't-care, so they are masked off
    // before comparing against the register offsets.
    assign word_addr   = 32'(reg_addr) & 32'hFFFF_FFFC;
    assign sel_cfg     = (word_addr == REG_CFG);
    assign sel_status  = (word_addr == REG_STATUS);
    assign sel_limit_l = (word_addr == REG_LIMIT_L);
    assign sel_limit_h = (word_addr == REG_LIMIT_H);
    assign sel_time_l  = (word_addr == REG_TIME_L);
    assign sel_time_h  = (word_addr == REG_TIME_H);

    assign limit_active = (limit_value != 64'd0);
    assign count_inc    = time_count + STEP64;

    // Configuration registers. clear_pulse is a one-cycle echo of a CFG
    // write with the clear bit set; it is never stored as a CFG bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_enable  <= 1'b0;
            clear_pulse <= 1'b0;
            limit_value <= 64'd0;
        end else begin
            clear_pulse <= reg_wr_en && sel_cfg && reg_wdata[CFG_CLEAR_BIT];
            if (reg_wr_en && sel_cfg) begin
                cfg_enable <= reg_wdata[CFG_ENABLE_BIT];
            end
            if (reg_wr_en && sel_limit_l) begin
                limit_value[31:0] <= reg_wdata;
            end
            if (reg_wr_en && sel_limit_h) begin
                limit_value[63:32] <= reg_wdata;
            end
        end
    end

    // Next-state and next-count logic. A pending clear wins over every
    // other rule. In RUNNING the "already at or past LIMIT" check comes
    // first so a limit lowered below the count stops without a jump; the
    // second check clamps the final step onto LIMIT exactly. The sum
    // wraps modulo 2^64, so a wrapped value never trips the compare.
    always_comb begin
        state_next = state;
        count_next = time_count;
        if (clear_pulse) begin
            count_next = 64'd0;
            state_next = cfg_enable ? ST_RUNNING : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_enable) begin
                        state_next = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (!cfg_enable) begin
                        state_next = ST_IDLE;
                    end else if (limit_active && (time_count >= limit_value)) begin
                        state_next = ST_LIMIT;
                    end else if (limit_active && (count_inc >= limit_value)) begin
                        count_next = limit_value;
                        state_next = ST_LIMIT;
                    end else begin
                        count_next = count_inc;
                    end
                end
                ST_LIMIT: begin
                    if (!cfg_enable) begin
                        state_next = ST_IDLE;
                    end else if (!limit_active || (time_count < limit_value)) begin
                        state_next = ST_RUNNING;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State, counter and the registered running flag. running_q is loaded
    // from state_next so it always equals (state == ST_RUNNING) without a
    // decode on the output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            time_count <= 64'd0;
            running_q  <= 1'b0;
        end else begin
            state      <= state_next;
            time_count <= count_next;
            running_q  <= (state_next == ST_RUNNING);
        end
    end

    // Read multiplexer over the pre-update register values, so a read and
    // write of the same register in one cycle returns the old contents.
    always_comb begin
        read_mux = 32'd0;
        if (sel_cfg) begin
            read_mux[CFG_ENABLE_BIT] = cfg_enable;
        end else if (sel_status) begin
            read_mux[STATUS_RUNNING_BIT] = (state == ST_RUNNING);
            read_mux[STATUS_LIMIT_BIT]   = (state == ST_LIMIT);
        end else if (sel_limit_l) begin
            read_mux = limit_value[31:0];
        end else if (sel_limit_h) begin
            read_mux = limit_value[63:32];
        end else if (sel_time_l) begin
            read_mux = time_count[31:0];
        end else if (sel_time_h) begin
            read_mux = snapshot;
        end
    end

    // Registered read port; a TIME_L read also freezes the matching
    // upper word for the following TIME_H read.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rdata  <= 32'd0;
            reg_rvalid <= 1'b0;
            snapshot   <= 32'd0;
        end else begin
            reg_rvalid <= reg_rd_en;
            reg_rdata  <= reg_rd_en ? read_mux : 32'd0;
            if (reg_rd_en && sel_time_l) begin
                snapshot <= time_count[63:32];
            end
        end
    end

    assign current_time = time_count;
    assign time_running = running_q;

endmodule

// File: tb/tb_eth_time_base.sv
// tb_eth_time_base
// Randomised and directed bench for eth_time_base. A behavioural model of
// the register map and time base is stepped on every clock edge and
// compared with the DUT just after the edge; directed sequences also pin
// literal values taken from hand calculation.
module tb_eth_time_base;

    localparam int STEP = 8;
    localparam int AW   = 5;

    localparam logic [4:0] A_CFG     = 5'h00;
    localparam logic [4:0] A_STATUS  = 5'h04;
    localparam logic [4:0] A_LIMIT_L = 5'h08;
    localparam logic [4:0] A_LIMIT_H = 5'h0C;
    localparam logic [4:0] A_TIME_L  = 5'h10;
    localparam logic [4:0] A_TIME_H  = 5'h14;

    logic          clk = 1'b0;
    logic          rst;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic [31:0]   reg_rdata;
    logic          reg_rvalid;
    logic [63:0]   current_time;
    logic          time_running;

    int total = 0;
    int bad   = 0;

    eth_time_base #(
        .C_STEP       (STEP),
        .C_ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_wr_en    (reg_wr_en),
        .reg_rd_en    (reg_rd_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .reg_rvalid   (reg_rvalid),
        .current_time (current_time),
        .time_running (time_running)
    );

    always #5 clk = ~clk;

    // Behavioural model state: what software would see in the registers,
    // plus "counting" / "stopped at limit" flags.
    bit          model_ok = 1'b0;
    bit          m_en, m_clr, m_run, m_hit, m_rvalid;
    logic [63:0] m_lim, m_cnt;
    logic [31:0] m_snap, m_rdata;

    bit          n_en, n_clr, n_run, n_hit;
    logic [63:0] n_lim, n_cnt, bump;
    logic [31:0] n_snap;
    logic [4:0]  m_word;

    // Counter preload requests from the stimulus process.
    int          dep_seq  = 0;
    int          dep_seen = 0;
    logic [63:0] dep_val;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [4:0] w;
        w = {a[4:2], 2'b00};
        case (w)
            A_CFG:     return {31'd0, m_en};
            A_STATUS:  return {30'd0, m_hit, m_run};
            A_LIMIT_L: return m_lim[31:0];
            A_LIMIT_H: return m_lim[63:32];
            A_TIME_L:  return m_cnt[31:0];
            A_TIME_H:  return m_snap;
            default:   return 32'd0;
        endcase
    endfunction

    // Model step on each edge, then a compare 1 ns later.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_en = 0; m_clr = 0; m_run = 0; m_hit = 0; m_rvalid = 0;
            m_lim = 0; m_cnt = 0; m_snap = 0; m_rdata = 0;
            dep_seen = dep_seq;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (dep_seq != dep_seen) begin
                m_cnt    = dep_val;
                dep_seen = dep_seq;
            end
            m_word = {reg_addr[4:2], 2'b00};
            n_snap = (reg_rd_en && m_word == A_TIME_L) ? m_cnt[63:32] : m_snap;
            n_cnt  = m_cnt;
            n_run  = m_run;
            n_hit  = m_hit;
            bump   = m_cnt + 64'(STEP);
            if (m_clr) begin
                n_cnt = 0;
                n_run = m_en;
                n_hit = 0;
            end else if (m_run) begin
                if (!m_en) begin
                    n_run = 0;
                end else if (m_lim != 0 && (m_cnt >= m_lim || bump >= m_lim)) begin
                    n_run = 0;
                    n_hit = 1;
                    if (m_cnt < m_lim) n_cnt = m_lim;
                end else begin
                    n_cnt = bump;
                end
            end else if (m_hit) begin
                if (!m_en) begin
                    n_hit = 0;
                end else if (m_lim == 0 || m_cnt < m_lim) begin
                    n_hit = 0;
                    n_run = 1;
                end
            end else if (m_en) begin
                n_run = 1;
            end
            n_en  = m_en;
            n_lim = m_lim;
            n_clr = 0;
            if (reg_wr_en) begin
                case (m_word)
                    A_CFG: begin
                        n_en  = reg_wdata[0];
                        n_clr = reg_wdata[1];
                    end
                    A_LIMIT_L: n_lim[31:0]  = reg_wdata;
                    A_LIMIT_H: n_lim[63:32] = reg_wdata;
                    default: ;
                endcase
            end
            m_rvalid = reg_rd_en;
            m_rdata  = reg_rd_en ? model_read(reg_addr) : 32'd0;
            m_snap = n_snap;
            m_cnt  = n_cnt;
            m_run  = n_run;
            m_hit  = n_hit;
            m_en   = n_en;
            m_lim  = n_lim;
            m_clr  = n_clr;
        end
        #1;
        if (model_ok) begin
            checkOutput("cmp_time", current_time, m_cnt);
            checkOutput("cmp_running", 64'(time_running), 64'(m_run));
            checkOutput("cmp_rvalid", 64'(reg_rvalid), 64'(m_rvalid));
            if (m_rvalid) checkOutput("cmp_rdata", 64'(reg_rdata), 64'(m_rdata));
        end
    end

    // Drive one cycle of register traffic starting at a falling edge.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [4:0] addr,
                                 input logic [31:0] data);
        reg_wr_en = wr;
        reg_rd_en = rd;
        reg_addr  = addr;
        reg_wdata = data;
        @(negedge clk);
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
    endtask

    // Preload the counter while the time base is stopped.
    task automatic preloadCount(input logic [63:0] value);
        force dut.time_count = value;
        dep_val = value;
        dep_seq++;
        @(negedge clk);
        release dut.time_count;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = '0; reg_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_time", current_time, 64'd0);
        checkOutput("reset_running", 64'(time_running), 64'd0);
        checkOutput("reset_rvalid", 64'(reg_rvalid), 64'd0);
        checkOutput("reset_rdata", 64'(reg_rdata), 64'd0);

        // Start: running two cycles after the write, then 0, 8, 16.
        applyStimulus(1, 0, A_CFG, 32'h1);
        checkOutput("start_c1_running", 64'(time_running), 64'd0);
        @(negedge clk);
        checkOutput("start_c2_running", 64'(time_running), 64'd1);
        checkOutput("start_c2_time", current_time, 64'd0);
        @(negedge clk);
        checkOutput("start_c3_time", current_time, 64'd8);
        @(negedge clk);
        checkOutput("start_c4_time", current_time, 64'd16);

        // Pause: one more step lands, then frozen at 24; resume from 24.
        applyStimulus(1, 0, A_CFG, 32'h0);
        checkOutput("pause_c1_time", current_time, 64'd24);
        @(negedge clk);
        checkOutput("pause_c2_running", 64'(time_running), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("pause_hold_time", current_time, 64'd24);
        end
        applyStimulus(1, 0, A_CFG, 32'h1);
        @(negedge clk);
        checkOutput("resume_c2_time", current_time, 64'd24);
        checkOutput("resume_c2_running", 64'(time_running), 64'd1);
        @(negedge clk);
        checkOutput("resume_c3_time", current_time, 64'd32);

        // Enable+clear while running.
        applyStimulus(1, 0, A_CFG, 32'h3);
        @(negedge clk);
        checkOutput("clear_c2_time", current_time, 64'd0);
        @(negedge clk);
        checkOutput("clear_c3_time", current_time, 64'd8);
        applyStimulus(0, 1, A_CFG, 32'h0);
        checkOutput("cfg_read_rvalid", 64'(reg_rvalid), 64'd1);
        checkOutput("cfg_read_data", 64'(reg_rdata), 64'd1);
        @(negedge clk);
        checkOutput("cfg_read_rvalid_drop", 64'(reg_rvalid), 64'd0);

        // Limit of 100: 0..96 then clamped to 100 and stopped.
        applyStimulus(1, 0, A_CFG, 32'h2);
        repeat (3) @(negedge clk);
        applyStimulus(1, 0, A_LIMIT_L, 32'd100);
        applyStimulus(1, 0, A_LIMIT_H, 32'd0);
        applyStimulus(1, 0, A_CFG, 32'h1);
        @(negedge clk);
        checkOutput("limit_first_time", current_time, 64'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput("limit_ramp_time", current_time, 64'(8 * k));
        end
        @(negedge clk);
        checkOutput("limit_clamp_time", current_time, 64'd100);
        checkOutput("limit_clamp_running", 64'(time_running), 64'd0);
        checkOutput("model_limit_time", m_cnt, 64'd100);
        applyStimulus(0, 1, A_STATUS, 32'h0);
        checkOutput("limit_status", 64'(reg_rdata), 64'h2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("limit_hold_time", current_time, 64'd100);
        end

        // Raise the limit to 120 with enable still set: 100, 108, 116, 120.
        applyStimulus(1, 0, A_LIMIT_L, 32'd120);
        @(negedge clk);
        checkOutput("relimit_running", 64'(time_running), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("relimit_time", current_time, 64'd120);
        checkOutput("relimit_stopped", 64'(time_running), 64'd0);
        applyStimulus(1, 0, A_CFG, 32'h0);
        repeat (2) @(negedge clk);
        applyStimulus(0, 1, A_STATUS, 32'h0);
        checkOutput("disable_status", 64'(reg_rdata), 64'h0);
        applyStimulus(1, 0, A_LIMIT_L, 32'd0);
        repeat (2) @(negedge clk);

        // Wrap past 2^64 without entering the limit state.
        preloadCount(64'hFFFF_FFFF_FFFF_FFF0);
        applyStimulus(1, 0, A_CFG, 32'h1);
        @(negedge clk);
        checkOutput("wrap_c2_time", current_time, 64'hFFFF_FFFF_FFFF_FFF0);
        @(negedge clk);
        checkOutput("wrap_c3_time", current_time, 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clk);
        checkOutput("wrap_c4_time", current_time, 64'h0);
        @(negedge clk);
        checkOutput("wrap_c5_time", current_time, 64'h8);
        checkOutput("wrap_c5_running", 64'(time_running), 64'd1);

        // Tear-free readback across a carry into the upper word.
        applyStimulus(1, 0, A_CFG, 32'h0);
        repeat (3) @(negedge clk);
        preloadCount(64'h0000_0001_FFFF_FFF8);
        applyStimulus(1, 0, A_CFG, 32'h1);
        @(negedge clk);
        applyStimulus(0, 1, A_TIME_L, 32'h0);
        checkOutput("snap_time_l", 64'(reg_rdata), 64'hFFFF_FFF8);
        checkOutput("snap_time_now", current_time, 64'h0000_0002_0000_0000);
        repeat (4) @(negedge clk);
        applyStimulus(0, 1, A_TIME_H, 32'h0);
        checkOutput("snap_time_h", 64'(reg_rdata), 64'h1);

        // Same-register read+write returns the old value; addr[1:0] ignored.
        applyStimulus(1, 1, A_LIMIT_H, 32'hABCD);
        checkOutput("rw_same_old", 64'(reg_rdata), 64'h0);
        applyStimulus(0, 1, 5'h0F, 32'h0);
        checkOutput("rw_same_new", 64'(reg_rdata), 64'hABCD);
        applyStimulus(1, 0, 5'h1C, 32'hFFFF_FFFF);
        applyStimulus(0, 1, 5'h1C, 32'h0);
        checkOutput("unmapped_read", 64'(reg_rdata), 64'h0);
        applyStimulus(1, 0, A_LIMIT_H, 32'h0);

        // Randomised traffic, checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = 5'($urandom_range(0, 31));
            case ({a[4:2], 2'b00})
                A_CFG:     d = ($urandom_range(0, 9) < 7) ? 32'h1 : 32'($urandom_range(0, 3));
                A_LIMIT_L: d = 32'($urandom_range(0, 400));
                A_LIMIT_H: d = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'h0;
                default:   d = 32'($urandom);
            endcase
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, a, d);
            rst = 1'b0;
        end

        // Reset mid-run, with a read in flight in the same cycle.
        applyStimulus(1, 0, A_LIMIT_H, 32'h0);
        applyStimulus(1, 0, A_LIMIT_L, 32'h0);
        applyStimulus(1, 0, A_CFG, 32'h1);
        repeat (6) @(negedge clk);
        checkOutput("midrun_running", 64'(time_running), 64'd1);
        rst = 1'b1;
        applyStimulus(0, 1, A_TIME_L, 32'h0);
        rst = 1'b0;
        checkOutput("rst_time", current_time, 64'd0);
        checkOutput("rst_running", 64'(time_running), 64'd0);
        checkOutput("rst_rvalid", 64'(reg_rvalid), 64'd0);
        checkOutput("rst_rdata", 64'(reg_rdata), 64'd0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
